// File: rtl/regfile_scb_pkg.sv
// Shared FSM state type and default parameter constants for regfile_scb.
package regfile_scb_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned DEPTH_DEF    = 32;
  localparam bit          ZERO_REG_DEF = 1'b1;

endpackage

// File: rtl/regfile_scb_scoreboard.sv
// Busy-bit scoreboard for regfile_scb: per-register busy flags with set/clear/clear-all
// and two combinational read ports. A set wins over a clear to the same address.
module regfile_scb_scoreboard
  import regfile_scb_pkg::*;
#(
  parameter  int unsigned DEPTH    = DEPTH_DEF,
  parameter  bit          ZERO_REG = ZERO_REG_DEF,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_all,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy
);

  logic [DEPTH-1:0] busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (clr_all) begin
      busy_d = '0;
    end else begin
      if (clr_en) busy_d[clr_addr] = 1'b0;
      if (set_en) busy_d[set_addr] = 1'b1;
    end
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_comb begin
    rs_busy = busy_q[rs_addr];
    rt_busy = busy_q[rt_addr];
  end

endmodule

// File: rtl/regfile_scb.sv
// regfile_scb: register file with busy scoreboard and a zeroing sweep after reset/clear.
// Define REGFILE_SCB_BYPASS_EN to forward same-cycle write data/busy onto the rs/rt ports.
module regfile_scb
  import regfile_scb_pkg::*;
#(
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned DEPTH    = DEPTH_DEF,
  parameter  bit          ZERO_REG = ZERO_REG_DEF,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              ready,
  input  logic [ADDR_W-1:0] rsAdd,
  input  logic [ADDR_W-1:0] rtAdd,
  output logic [DATA_W-1:0] rsOut,
  output logic [DATA_W-1:0] rtOut,
  output logic              rsBusy,
  output logic              rtBusy,
  input  logic              wrEnable,
  input  logic [ADDR_W-1:0] wrAdd,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rsvEnable,
  input  logic [ADDR_W-1:0] rsvAdd,
  input  logic [ADDR_W-1:0] dbgAdd,
  output logic [DATA_W-1:0] dbgOut
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              sweep_fire;
  logic              wr_fire;
  logic              rsv_fire;
  logic              sb_rs_busy, sb_rt_busy;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (clr) begin
      state_d = INIT;
      sweep_d = '0;
    end else if (state_q == INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == LAST_ADDR) state_d = READY;
    end
  end

  always_comb begin
    ready      = (state_q == READY);
    sweep_fire = (state_q == INIT) && !clr;
    wr_fire    = ready && !clr && wrEnable  && !is_zero_reg(wrAdd);
    rsv_fire   = ready && !clr && rsvEnable && !is_zero_reg(rsvAdd);
  end

  // No reset on the array so it can map to RAM; the INIT sweep is the only clear.
  always_ff @(posedge clk) begin
    if (sweep_fire) begin
      mem_q[sweep_q] <= '0;
    end else if (wr_fire) begin
      mem_q[wrAdd] <= wrData;
    end
  end

  regfile_scb_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst),
    .clr_all  (clr),
    .set_en   (rsv_fire),
    .set_addr (rsvAdd),
    .clr_en   (wr_fire),
    .clr_addr (wrAdd),
    .rs_addr  (rsAdd),
    .rt_addr  (rtAdd),
    .rs_busy  (sb_rs_busy),
    .rt_busy  (sb_rt_busy)
  );

  always_comb begin
    rsOut  = mem_q[rsAdd];
    rtOut  = mem_q[rtAdd];
    dbgOut = mem_q[dbgAdd];
    rsBusy = sb_rs_busy;
    rtBusy = sb_rt_busy;
`ifdef REGFILE_SCB_BYPASS_EN
    // Bypassed busy reflects the post-edge value: the write clears it unless reserved again.
    if (wr_fire && (wrAdd == rsAdd)) begin
      rsOut  = wrData;
      rsBusy = rsv_fire && (rsvAdd == rsAdd);
    end
    if (wr_fire && (wrAdd == rtAdd)) begin
      rtOut  = wrData;
      rtBusy = rsv_fire && (rsvAdd == rtAdd);
    end
`endif
    if (!ready || is_zero_reg(rsAdd)) begin
      rsOut  = '0;
      rsBusy = 1'b0;
    end
    if (!ready || is_zero_reg(rtAdd)) begin
      rtOut  = '0;
      rtBusy = 1'b0;
    end
    if (!ready || is_zero_reg(dbgAdd)) dbgOut = '0;
  end

endmodule
